// File: rtl/match_run_sched_if.sv
// Bundles the request/data, grant and result-handshake signals of match_run_sched.
// The master side (testbench or upstream logic) drives requests and accepts results.
interface match_run_sched_if #(
  parameter int THR_W = 4,
  parameter int TMO_W = 8
);
  logic [3:0]       req;
  logic [3:0]       a_in;
  logic [3:0]       b_in;
  logic [THR_W-1:0] thresh;
  logic [TMO_W-1:0] max_cycles;
  logic [3:0]       gnt;
  logic             busy;
  logic             res_valid;
  logic [1:0]       res_ch;
  logic             res_match;
  logic             res_ready;

  modport master (
    output req, a_in, b_in, thresh, max_cycles, res_ready,
    input  gnt, busy, res_valid, res_ch, res_match
  );

  modport slave (
    input  req, a_in, b_in, thresh, max_cycles, res_ready,
    output gnt, busy, res_valid, res_ch, res_match
  );
endinterface

// File: rtl/match_run_sched.sv
// Round-robin scheduler that grants one of four channels and checks for a run of
// consecutive A==B matches within a timeout window, reporting through a valid/ready handshake.
module match_run_sched #(
  parameter int THR_W = 4,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  match_run_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    RUN    = 3'b010,
    REPORT = 3'b100
  } state_t;

  state_t           state;
  logic [1:0]       last;
  logic [1:0]       ch;
  logic [1:0]       pick;
  logic [3:0]       gnt;
  logic             res_valid;
  logic             res_match;
  logic [THR_W-1:0] thr_lat;
  logic [THR_W-1:0] run_cnt;
  logic [THR_W:0]   run_nxt;
  logic [TMO_W:0]   win_lat;
  logic [TMO_W:0]   timer;
  logic [TMO_W:0]   timer_nxt;
  logic             match_bit;
  logic             hit;

  // Nearest requester after the last served channel wins; scan from far to near.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    rr_pick = l + 2'd1;
    for (int i = 4; i >= 1; i--) begin
      idx = l + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [THR_W-1:0] eff_thr(input logic [THR_W-1:0] t);
    return (t == '0) ? THR_W'(1) : t;
  endfunction

  // A zero window means the full 2^TMO_W cycles, hence the extra timer bit.
  function automatic logic [TMO_W:0] eff_win(input logic [TMO_W-1:0] m);
    return (m == '0) ? {1'b1, {TMO_W{1'b0}}} : {1'b0, m};
  endfunction

  always_comb begin
    pick      = rr_pick(bus.req, last);
    match_bit = (bus.a_in[ch] == bus.b_in[ch]);
    run_nxt   = {1'b0, run_cnt} + (THR_W+1)'(1);
    hit       = match_bit && (run_nxt == {1'b0, thr_lat});
    timer_nxt = timer + (TMO_W+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 2'd3;
      ch        <= '0;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_match <= 1'b0;
      thr_lat   <= '0;
      win_lat   <= '0;
      run_cnt   <= '0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req != 4'b0000) begin
            ch      <= pick;
            gnt     <= 4'b0001 << pick;
            thr_lat <= eff_thr(bus.thresh);
            win_lat <= eff_win(bus.max_cycles);
            run_cnt <= '0;
            timer   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!bus.req[ch]) begin
            gnt   <= '0;
            state <= IDLE;
          end else begin
            timer   <= timer_nxt;
            run_cnt <= match_bit ? run_nxt[THR_W-1:0] : '0;
            // Success is checked first so it wins a tie with the timeout.
            if (hit) begin
              res_valid <= 1'b1;
              res_match <= 1'b1;
              state     <= REPORT;
            end else if (timer_nxt == win_lat) begin
              res_valid <= 1'b1;
              res_match <= 1'b0;
              state     <= REPORT;
            end
          end
        end
        REPORT: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            gnt       <= '0;
            last      <= ch;
            state     <= IDLE;
          end
        end
        default: begin
          gnt       <= '0;
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.busy      = (state != IDLE);
  assign bus.res_valid = res_valid;
  assign bus.res_ch    = ch;
  assign bus.res_match = res_match;

endmodule

// File: tb/tb_match_run_sched.sv
// Self-checking bench for match_run_sched: directed scenarios plus randomized
// transactions checked against a run-length/round-robin reference model.
module tb_match_run_sched;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_m = 3;

  always #5 clk = ~clk;

  match_run_sched_if #(.THR_W(4), .TMO_W(8)) bus();

  match_run_sched #(.THR_W(4), .TMO_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference: round-robin choice starting after the last served channel.
  function automatic int rr_model(input logic [3:0] rq, input int last);
    for (int i = 1; i <= 4; i++) if (rq[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction

  // Reference: RUN cycle at which the result appears and whether it is a match.
  task automatic outcome_model(input int th, input int mc, input logic [255:0] pat,
                               output int cyc, output logic m);
    int thr, win, run;
    thr = (th == 0) ? 1 : th;
    win = (mc == 0) ? 256 : mc;
    run = 0;
    cyc = win;
    m   = 1'b0;
    for (int k = 1; k <= win; k++) begin
      run = pat[k-1] ? run + 1 : 0;
      if (run >= thr) begin
        cyc = k;
        m   = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    bus.req = '0; bus.res_ready = 1'b0; bus.a_in = '0; bus.b_in = '0;
    #2 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    last_m = 3;
  endtask

  // Drives one transaction from IDLE to handshake and reports what was observed.
  task automatic drive_txn(input logic [3:0] rq, input int th, input int mc,
                           input logic [255:0] pat, input int hold,
                           output int t_gnt, output logic [3:0] gnt_o, output int t_res,
                           output logic [1:0] ch_o, output logic m_o, output logic stable_o);
    int  ch;
    logic a;
    bus.req = rq; bus.thresh = 4'(th); bus.max_cycles = 8'(mc); bus.res_ready = 1'b0;
    t_gnt = -1; t_res = -1; gnt_o = '0; ch_o = '0; m_o = 1'b0; stable_o = 1'b1; ch = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (bus.gnt != 4'b0000) begin t_gnt = i; break; end
    end
    if (t_gnt < 0) begin bus.req = '0; return; end
    gnt_o = bus.gnt;
    for (int i = 0; i < 4; i++) if (gnt_o[i]) ch = i;
    for (int c = 0; c < 300; c++) begin
      bus.a_in = 4'($urandom); bus.b_in = 4'($urandom);
      a = bus.a_in[ch];
      bus.b_in[ch] = ((c < 256) ? pat[c] : 1'b0) ? a : ~a;
      bus.req = 4'($urandom) | gnt_o;
      bus.res_ready = 1'($urandom);
      @(posedge clk); #1;
      if (bus.gnt !== gnt_o || bus.busy !== 1'b1) stable_o = 1'b0;
      if (bus.res_valid === 1'b1) begin t_res = c + 1; break; end
    end
    bus.res_ready = 1'b0;
    if (t_res < 0) begin bus.req = '0; return; end
    ch_o = bus.res_ch; m_o = bus.res_match;
    for (int i = 0; i < hold; i++) begin
      bus.req = 4'($urandom) | gnt_o; bus.a_in = 4'($urandom); bus.b_in = 4'($urandom);
      @(posedge clk); #1;
      if (bus.res_valid !== 1'b1 || bus.res_ch !== ch_o || bus.res_match !== m_o ||
          bus.gnt !== gnt_o || bus.busy !== 1'b1) stable_o = 1'b0;
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0; bus.req = '0;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.thresh = '0; bus.max_cycles = '0;
    bus.res_ready = 1'b0;
    #1 reset = 1'b1;
    #2;
    n_checks++; if ({bus.gnt, bus.busy, bus.res_valid, bus.res_ch, bus.res_match} !== 9'b0) begin
      n_errors++; $display("FAIL reset_async: got %b expected 0",
        {bus.gnt, bus.busy, bus.res_valid, bus.res_ch, bus.res_match}); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({bus.gnt, bus.busy, bus.res_valid, bus.res_ch, bus.res_match} !== 9'b0) begin
      n_errors++; $display("FAIL reset_idle: got %b expected 0",
        {bus.gnt, bus.busy, bus.res_valid, bus.res_ch, bus.res_match}); end
    last_m = 3;
  endtask

  task automatic test_basic();
    int t_gnt, t_res, ecyc; logic [3:0] g; logic [1:0] c; logic m, st, em;
    logic [255:0] pat;
    pat = '1;
    outcome_model(4, 20, pat, ecyc, em);
    drive_txn(4'b0001, 4, 20, pat, 0, t_gnt, g, t_res, c, m, st);
    n_checks++; if (t_gnt !== 1) begin n_errors++; $display("FAIL basic_gnt_cycle: got %0d expected 1", t_gnt); end
    n_checks++; if (g !== 4'b0001) begin n_errors++; $display("FAIL basic_gnt: got %b expected 0001", g); end
    n_checks++; if (t_gnt + t_res !== 5) begin n_errors++; $display("FAIL basic_latency: got %0d expected 5", t_gnt + t_res); end
    n_checks++; if (t_res !== ecyc) begin n_errors++; $display("FAIL basic_run_cycles: got %0d expected %0d", t_res, ecyc); end
    n_checks++; if (c !== 2'd0 || m !== em) begin n_errors++; $display("FAIL basic_result: got ch %0d match %b expected ch 0 match %b", c, m, em); end
    n_checks++; if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      n_errors++; $display("FAIL basic_idle: got gnt %b busy %b valid %b expected 0", bus.gnt, bus.busy, bus.res_valid); end
    last_m = 0;
  endtask

  task automatic test_timeout();
    int t_gnt, t_res, ecyc; logic [3:0] g; logic [1:0] c; logic m, st, em;
    logic [255:0] pat;
    pat = '0; pat[5:0] = 6'b110111;  // cycles 1..6 : 1,1,1,0,1,1
    outcome_model(4, 6, pat, ecyc, em);
    drive_txn(4'b0001, 4, 6, pat, 0, t_gnt, g, t_res, c, m, st);
    n_checks++; if (t_res !== 6 || t_res !== ecyc) begin n_errors++; $display("FAIL timeout_cycles: got %0d expected 6", t_res); end
    n_checks++; if (m !== 1'b0 || m !== em) begin n_errors++; $display("FAIL timeout_match: got %b expected 0", m); end
    last_m = 0;
  endtask

  task automatic test_tie();
    int t_gnt, t_res, ecyc; logic [3:0] g; logic [1:0] c; logic m, st, em;
    logic [255:0] pat;
    pat = '0; pat[2:0] = 3'b111;
    outcome_model(3, 3, pat, ecyc, em);
    drive_txn(4'b0001, 3, 3, pat, 0, t_gnt, g, t_res, c, m, st);
    n_checks++; if (t_res !== ecyc) begin n_errors++; $display("FAIL tie_cycles: got %0d expected %0d", t_res, ecyc); end
    n_checks++; if (m !== 1'b1) begin n_errors++; $display("FAIL tie_match: got %b expected 1", m); end
    last_m = 0;
  endtask

  task automatic test_hold();
    int t_gnt, t_res, ecyc; logic [3:0] g; logic [1:0] c; logic m, st, em;
    logic [255:0] pat;
    pat = '1;
    outcome_model(2, 10, pat, ecyc, em);
    drive_txn(4'b0010, 2, 10, pat, 10, t_gnt, g, t_res, c, m, st);
    n_checks++; if (g !== 4'b0010 || c !== 2'd1) begin n_errors++; $display("FAIL hold_ch: got gnt %b ch %0d expected 0010 ch 1", g, c); end
    n_checks++; if (st !== 1'b1) begin n_errors++; $display("FAIL hold_stable: got %b expected 1", st); end
    n_checks++; if (t_res !== ecyc || m !== em) begin n_errors++; $display("FAIL hold_result: got %0d/%b expected %0d/%b", t_res, m, ecyc, em); end
    n_checks++; if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      n_errors++; $display("FAIL hold_release: got gnt %b busy %b valid %b expected 0", bus.gnt, bus.busy, bus.res_valid); end
    last_m = 1;
  endtask

  task automatic test_zero_params();
    int t_gnt, t_res, ecyc; logic [3:0] g; logic [1:0] c; logic m, st, em;
    logic [255:0] pat;
    pat = '1;
    outcome_model(0, 5, pat, ecyc, em);
    drive_txn(4'b1000, 0, 5, pat, 0, t_gnt, g, t_res, c, m, st);
    n_checks++; if (t_res !== 1 || t_res !== ecyc || m !== 1'b1) begin
      n_errors++; $display("FAIL zero_thresh: got %0d/%b expected 1/1", t_res, m); end
    n_checks++; if (c !== 2'd3) begin n_errors++; $display("FAIL zero_thresh_ch: got %0d expected 3", c); end
    last_m = 3;
    pat = '0;
    outcome_model(3, 0, pat, ecyc, em);
    drive_txn(4'b0001, 3, 0, pat, 0, t_gnt, g, t_res, c, m, st);
    n_checks++; if (t_res !== 256 || t_res !== ecyc || m !== 1'b0) begin
      n_errors++; $display("FAIL zero_window: got %0d/%b expected 256/0", t_res, m); end
    last_m = 0;
  endtask

  task automatic test_abort();
    logic seen_valid;
    seen_valid = 1'b0;
    bus.req = 4'b0100; bus.thresh = 4'd5; bus.max_cycles = 8'd50;
    bus.a_in = 4'b0000; bus.b_in = 4'b0100;
    @(posedge clk); #1;
    n_checks++; if (bus.gnt !== (4'b0001 << rr_model(4'b0100, last_m))) begin
      n_errors++; $display("FAIL abort_gnt: got %b expected 0100", bus.gnt); end
    repeat (2) begin @(posedge clk); #1; if (bus.res_valid !== 1'b0) seen_valid = 1'b1; end
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL abort_busy_run: got %b expected 1", bus.busy); end
    bus.req = 4'b1011;
    @(posedge clk); #1;
    if (bus.res_valid !== 1'b0) seen_valid = 1'b1;
    n_checks++; if (bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL abort_idle: got gnt %b busy %b expected 0", bus.gnt, bus.busy); end
    @(posedge clk); #1;
    n_checks++; if (bus.gnt !== (4'b0001 << rr_model(4'b1011, last_m))) begin
      n_errors++; $display("FAIL abort_last_kept: got %b expected %b", bus.gnt, 4'b0001 << rr_model(4'b1011, last_m)); end
    bus.req = 4'b0000;
    @(posedge clk); #1;
    if (bus.res_valid !== 1'b0) seen_valid = 1'b1;
    n_checks++; if (bus.gnt !== 4'b0 || seen_valid !== 1'b0) begin
      n_errors++; $display("FAIL abort_no_result: got gnt %b valid_seen %b expected 0/0", bus.gnt, seen_valid); end
  endtask

  task automatic test_back_to_back();
    int seq[5];
    int l, n, ph;
    logic [3:0] eg;
    do_reset();
    l = last_m;
    for (int i = 0; i < 5; i++) begin seq[i] = rr_model(4'b1111, l); l = seq[i]; end
    bus.a_in = 4'b0000; bus.b_in = 4'b0000; bus.thresh = 4'd1; bus.max_cycles = 8'd20;
    bus.res_ready = 1'b1; bus.req = 4'b1111;
    // Threshold 1: grant cycle, one RUN cycle into REPORT, then one IDLE cycle.
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      n  = (k - 1) / 3;
      ph = (k - 1) % 3;
      eg = (ph < 2) ? (4'b0001 << seq[n]) : 4'b0000;
      n_checks++; if (bus.gnt !== eg || bus.res_valid !== (ph == 1)) begin
        n_errors++; $display("FAIL b2b_cycle%0d: got gnt %b valid %b expected gnt %b valid %b", k, bus.gnt, bus.res_valid, eg, ph == 1); end
      if (ph == 1) begin
        n_checks++; if (bus.res_ch !== 2'(seq[n])) begin
          n_errors++; $display("FAIL b2b_res_ch%0d: got %0d expected %0d", n, bus.res_ch, seq[n]); end
      end
    end
    bus.req = '0; bus.res_ready = 1'b0;
    last_m = seq[4];
  endtask

  task automatic test_reset_mid();
    logic seen_valid;
    seen_valid = 1'b0;
    bus.req = 4'b0010; bus.thresh = 4'd1; bus.max_cycles = 8'd20;
    bus.a_in = 4'b0000; bus.b_in = 4'b0000; bus.res_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_ch !== 2'(rr_model(4'b0010, last_m))) begin
      n_errors++; $display("FAIL mid_report_reached: got valid %b ch %0d expected 1/1", bus.res_valid, bus.res_ch); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({bus.gnt, bus.busy, bus.res_valid, bus.res_ch, bus.res_match} !== 9'b0) begin
      n_errors++; $display("FAIL mid_report_reset: got %b expected 0",
        {bus.gnt, bus.busy, bus.res_valid, bus.res_ch, bus.res_match}); end
    @(posedge clk); #1;
    reset = 1'b0; bus.req = 4'b0010; bus.thresh = 4'd5;
    last_m = 3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b1 || bus.gnt !== 4'b0010) begin
      n_errors++; $display("FAIL mid_run_reached: got busy %b gnt %b expected 1/0010", bus.busy, bus.gnt); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin
      n_errors++; $display("FAIL mid_run_reset: got busy %b gnt %b expected 0/0", bus.busy, bus.gnt); end
    @(posedge clk); #1;
    reset = 1'b0; bus.req = 4'b0000;
    repeat (6) begin @(posedge clk); #1; if (bus.res_valid !== 1'b0) seen_valid = 1'b1; end
    n_checks++; if (seen_valid !== 1'b0) begin n_errors++; $display("FAIL mid_no_pulse: got %b expected 0", seen_valid); end
    last_m = 3;
  endtask

  task automatic test_random();
    int t_gnt, t_res, ecyc, th, mc, hold, ech;
    logic [3:0] g, rq; logic [1:0] c; logic m, st, em;
    logic [255:0] pat;
    for (int n = 0; n < 25; n++) begin
      rq   = 4'($urandom_range(1, 15));
      th   = $urandom_range(0, 6);
      mc   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 14);
      hold = $urandom_range(0, 3);
      for (int i = 0; i < 256; i++) pat[i] = ($urandom_range(0, 3) != 0);
      ech = rr_model(rq, last_m);
      outcome_model(th, mc, pat, ecyc, em);
      drive_txn(rq, th, mc, pat, hold, t_gnt, g, t_res, c, m, st);
      n_checks++; if (t_gnt !== 1 || g !== (4'b0001 << ech)) begin
        n_errors++; $display("FAIL rand%0d_gnt: got %b at %0d expected %b at 1", n, g, t_gnt, 4'b0001 << ech); end
      n_checks++; if (t_res !== ecyc) begin
        n_errors++; $display("FAIL rand%0d_cycles: got %0d expected %0d (th %0d mc %0d)", n, t_res, ecyc, th, mc); end
      n_checks++; if (m !== em || c !== 2'(ech)) begin
        n_errors++; $display("FAIL rand%0d_result: got match %b ch %0d expected %b ch %0d", n, m, c, em, ech); end
      n_checks++; if (st !== 1'b1) begin n_errors++; $display("FAIL rand%0d_stable: got %b expected 1", n, st); end
      n_checks++; if (bus.gnt !== 4'b0 || bus.res_valid !== 1'b0) begin
        n_errors++; $display("FAIL rand%0d_idle: got gnt %b valid %b expected 0", n, bus.gnt, bus.res_valid); end
      last_m = ech;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_tie();
    test_hold();
    test_zero_params();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/match_run_sched.md
MATCH_RUN_SCHED -- requirements
Module: match_run_sched

Interface
REQ-001 SHALL have parameter THR_W, default 4: width of the run-length threshold.
REQ-002 SHALL have parameter TMO_W, default 8: width of the timeout window.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 4: per-channel request for an equality-run check, level-held.
REQ-006 SHALL have port a_in, input, 4: per-channel A bit stream.
REQ-007 SHALL have port b_in, input, 4: per-channel B bit stream.
REQ-008 SHALL have port thresh, input, THR_W: required consecutive matches, sampled at grant.
REQ-009 SHALL have port max_cycles, input, TMO_W: timeout window in RUN cycles, sampled at grant.
REQ-010 SHALL have port gnt, output, 4: one-hot grant, registered.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port res_valid, output, 1: result valid.
REQ-013 SHALL have port res_ch, output, 2: channel index of the result.
REQ-014 SHALL have port res_match, output, 1: 1 = run reached, 0 = timeout.
REQ-015 SHALL have port res_ready, input, 1: result accept.

Function
REQ-016 SHALL implement a one-hot FSM with states IDLE, RUN and REPORT; an illegal encoding SHALL go to IDLE with gnt=0 on the next edge.
REQ-017 IDLE: if req!=0, SHALL select round-robin starting at (last+1) mod 4.
REQ-018 On leaving IDLE, SHALL set gnt, latch thresh and max_cycles, clear the run counter and timer, and enter RUN on the next edge.
REQ-019 SHALL produce gnt one cycle after req is seen.
REQ-020 SHALL treat thresh=0 as 1 and max_cycles=0 as 2^TMO_W.
REQ-021 RUN, per cycle on the granted channel g: if a_in[g]==b_in[g], run counter +1; else run counter =0.
REQ-022 RUN: the timer SHALL increment every cycle.
REQ-023 RUN: when a matching cycle makes the run counter equal to the threshold, SHALL enter REPORT with res_match=1.
REQ-024 RUN: when the timer reaches the window with no success, SHALL enter REPORT with res_match=0.
REQ-025 If success and timeout occur in the same cycle, success SHALL win.
REQ-026 If req[g] drops during RUN, SHALL abort to IDLE, clear gnt, produce no result, and leave last unchanged.
REQ-027 REPORT: res_valid=1 with res_ch=g, and res_match SHALL be held stable until res_ready=1.
REQ-028 On the REPORT handshake edge, SHALL clear res_valid and gnt, set last=g, and go to IDLE.
REQ-029 Minimum spacing between grants SHALL be one IDLE cycle.
REQ-030 res_ready asserted outside REPORT SHALL be ignored.
REQ-031 Changes on req for other channels SHALL not affect an active RUN or REPORT.
REQ-032 Best-case latency from req to res_valid SHALL be threshold+1 cycles.

Reset
REQ-033 On reset, SHALL immediately force state=IDLE.
REQ-034 On reset, SHALL set gnt=0, busy=0, res_valid=0, res_ch=0, res_match=0.
REQ-035 On reset, SHALL clear the counters and set last=3, so channel 0 has first priority.
REQ-036 Reset asserted mid-RUN or mid-REPORT SHALL discard the result with no res_valid pulse.

Verification
REQ-037 Reset, then req=0001, thresh=4, max_cycles=20, a_in[0]==b_in[0] constant -> gnt=0001 at cycle 1, res_valid at cycle 5, res_ch=0, res_match=1.
REQ-038 req=1111 held, instant matches, res_ready=1 -> grants in the order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-039 thresh=4, max_cycles=6, match pattern 1,1,1,0,1,1 -> res_match=0 after 6 RUN cycles.
REQ-040 thresh=3, max_cycles=3, three matches -> res_match=1, because success wins the tie.
REQ-041 res_ready held low 10 cycles in REPORT -> res_valid, res_ch and res_match stable; gnt stays set; release -> IDLE next edge.
REQ-042 req[g] dropped mid-RUN -> IDLE, gnt=0, no res_valid; reset pulse mid-REPORT -> all outputs 0 immediately.
